crossbar_rr_wormhole: RTL
=========================

// Module: crossbar_rr_wormhole
// PURPOSE
//  Next-generation router crossbar. Per-output round-robin arbitration is built in,
//  so the separate grant vector is no longer needed. Multi-flit packets use wormhole
//  locking, and each output has a registered valid/ready stage for backpressure.
//  Sits between the input buffers and the output links of each router.
// PARAMETERS
//  DATA_WIDTH     32  flit payload width
//  IN_PORTS       5   number of input ports
//  OUT_PORTS      5   number of output ports
//  IN_PORT_BITS   3   width of a source-port index (>= clog2(IN_PORTS))
//  OUT_PORT_BITS  3   width of a destination-port index (>= clog2(OUT_PORTS))
// PORTS
//  clk        in   1                        single clock, rising edge
//  reset      in   1                        asynchronous, active-low (0 = reset)
//  in_data    in   IN_PORTS*DATA_WIDTH      flit i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//  req_ports  in   IN_PORTS*OUT_PORT_BITS   destination of input i, same slicing
//  in_valid   in   IN_PORTS                 input i presents a flit
//  in_tail    in   IN_PORTS                 flit on input i is the last of its packet
//  in_ready   out  IN_PORTS                 flit on input i is consumed this cycle
//  out_data   out  OUT_PORTS*DATA_WIDTH     registered flit per output
//  out_src    out  OUT_PORTS*IN_PORT_BITS   source input of the held flit
//  out_tail   out  OUT_PORTS                held flit is a tail
//  out_valid  out  OUT_PORTS                output o holds a flit
//  out_ready  in   OUT_PORTS                downstream accepts output o this cycle
//  err_port   out  IN_PORTS                 1-cycle pulse: input i requested a port >= OUT_PORTS
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - out_valid, out_data, out_src, out_tail, err_port clear to 0.
//   - Per-output pointer ptr[o], lock[o] and owner[o] clear to 0.
//   - Any partial packet is discarded. Reset mid-packet frees every lock.
//  Output slot o is free when !out_valid[o] || out_ready[o], i.e. pipeline-ready with no bubble.
//  Candidates for output o:
//   - Inputs i with in_valid[i] && req_ports[i]==o.
//   - While lock[o]=1, only owner[o] is eligible.
//  Arbitration: the winner is the first candidate scanning i = ptr[o], ptr[o]+1, ... (mod IN_PORTS).
//   A winner is granted only if the slot is free.
//  Grant effects:
//   - in_ready[winner] = 1 combinationally in the same cycle.
//   - At the next edge the output stage loads data, src=winner and tail, and out_valid[o] <= 1.
//  Latency: exactly 1 cycle from acceptance to out_valid.
//  Lock and pointer update:
//   - Granted non-tail flit: lock[o] <= 1, owner[o] <= winner.
//   - Granted tail flit: lock[o] <= 0, ptr[o] <= (winner+1) mod IN_PORTS.
//   - The pointer advances only at packet end, so fairness is per packet.
//   - A single flit with tail=1 never locks.
//  Hold: while out_valid[o] && !out_ready[o], out_data/out_src/out_tail are held stable.
//   Handshake rules:
//   - If out_ready[o]=1 and no grant, out_valid[o] <= 0.
//   - in_ready may depend on in_valid. in_valid must not depend on in_ready.
//   - in_valid and data stay stable until in_ready.
//  Bad port: in_valid[i] with req_ports[i] >= OUT_PORTS gives in_ready[i]=1.
//   The flit is dropped and err_port[i] pulses the next cycle. No output or lock state changes.
//  Each input targets one output per cycle, so no input is double-granted.
//   Senders keep req_ports constant within a packet; violations are undefined.
//  Outputs are fully independent. All outputs may grant in the same cycle.
// TESTING
//  1. Single flit to output 2:
//     - Stimulus: in0 valid, req=2, tail=1, data=0xA5A50001, out_ready=all 1.
//     - Response: in_ready[0]=1 same cycle. Next cycle out_valid[2]=1, out_data[2]=0xA5A50001, out_src[2]=0.
//  2. Round robin on output 0:
//     - Stimulus: in1 and in3 send back-to-back single flits to out0 after reset.
//     - Response: out_src[0] sequence is 1,3,1,3 with no idle cycles.
//  3. Wormhole lock on output 4:
//     - Stimulus: in0 sends a 3-flit packet to out4. In the same cycle in1 sends a single flit to out4.
//     - Response: out4 carries in0 f0,f1,f2 then in1. in_ready[1]=0 for 3 cycles.
//  4. Backpressure on output 1:
//     - Stimulus: out_ready[1]=0 for 4 cycles while out_valid[1]=1.
//     - Response: out_data[1] is stable and in_ready=0 for contenders. After release, the next flit follows with no bubble.
//  5. Bad port:
//     - Stimulus: in2 valid with req=7 (OUT_PORTS=5).
//     - Response: in_ready[2]=1, no out_valid change, err_port[2]=1 for exactly 1 cycle.
//  6. Reset mid-packet:
//     - Stimulus: assert reset between flit 1 and flit 2 of in0's packet to out3.
//     - Response: out_valid=0 immediately. After release, an in4 single flit to out3 is granted in its first valid cycle.

Source files
------------

// File: rtl/crossbar_rr_wormhole.sv
// Router crossbar: per-output round-robin arbitration, wormhole packet locking,
// and a registered valid/ready output stage per output link.
module crossbar_rr_wormhole #(
    parameter int DATA_WIDTH    = 32,
    parameter int IN_PORTS      = 5,
    parameter int OUT_PORTS     = 5,
    parameter int IN_PORT_BITS  = 3,
    parameter int OUT_PORT_BITS = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [IN_PORTS*DATA_WIDTH-1:0]    in_data,
    input  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports,
    input  logic [IN_PORTS-1:0]               in_valid,
    input  logic [IN_PORTS-1:0]               in_tail,
    output logic [IN_PORTS-1:0]               in_ready,
    output logic [OUT_PORTS*DATA_WIDTH-1:0]   out_data,
    output logic [OUT_PORTS*IN_PORT_BITS-1:0] out_src,
    output logic [OUT_PORTS-1:0]              out_tail,
    output logic [OUT_PORTS-1:0]              out_valid,
    input  logic [OUT_PORTS-1:0]              out_ready,
    output logic [IN_PORTS-1:0]               err_port
);

    logic [IN_PORTS-1:0]     bad_port;
    logic [IN_PORTS-1:0]     err_q;
    logic [OUT_PORTS-1:0]    grant;
    logic [IN_PORT_BITS-1:0] winner [OUT_PORTS];

    genvar gi;

    // Out-of-range destinations are consumed and dropped so the input never stalls.
    generate
        for (gi = 0; gi < IN_PORTS; gi++) begin : g_bad
            assign bad_port[gi] = in_valid[gi] &&
                (32'(req_ports[gi*OUT_PORT_BITS +: OUT_PORT_BITS]) >= OUT_PORTS);
        end
    endgenerate

    generate
        for (gi = 0; gi < OUT_PORTS; gi++) begin : g_out
            logic [IN_PORTS-1:0]     cand;
            logic                    found;
            logic [IN_PORT_BITS-1:0] win;
            logic                    win_tail;
            logic [DATA_WIDTH-1:0]   win_data;
            logic [IN_PORT_BITS-1:0] ptr_q, ptr_d, owner_q, owner_d, src_q, src_d;
            logic                    lock_q, lock_d, valid_q, valid_d, tail_q, tail_d;
            logic [DATA_WIDTH-1:0]   data_q, data_d;

            always_comb begin
                for (int i = 0; i < IN_PORTS; i++) begin
                    cand[i] = in_valid[i]
                        && (32'(req_ports[i*OUT_PORT_BITS +: OUT_PORT_BITS]) == gi)
                        && (!lock_q || (32'(owner_q) == i));
                end
            end

            // Two passes give the circular scan starting at ptr_q without a modulo.
            always_comb begin
                found = 1'b0;
                win   = ptr_q;
                for (int i = 0; i < IN_PORTS; i++) begin
                    if (!found && cand[i] && (32'(ptr_q) <= i)) begin
                        found = 1'b1;
                        win   = IN_PORT_BITS'(i);
                    end
                end
                for (int i = 0; i < IN_PORTS; i++) begin
                    if (!found && cand[i] && (32'(ptr_q) > i)) begin
                        found = 1'b1;
                        win   = IN_PORT_BITS'(i);
                    end
                end
            end

            always_comb begin
                win_data = '0;
                win_tail = 1'b0;
                for (int i = 0; i < IN_PORTS; i++) begin
                    if (32'(win) == i) begin
                        win_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                        win_tail = in_tail[i];
                    end
                end
            end

            assign grant[gi]  = found && (!valid_q || out_ready[gi]);
            assign winner[gi] = win;

            always_comb begin
                ptr_d   = ptr_q;
                owner_d = owner_q;
                lock_d  = lock_q;
                valid_d = valid_q;
                data_d  = data_q;
                src_d   = src_q;
                tail_d  = tail_q;
                if (grant[gi]) begin
                    valid_d = 1'b1;
                    data_d  = win_data;
                    src_d   = win;
                    tail_d  = win_tail;
                    if (win_tail) begin
                        lock_d = 1'b0;
                        ptr_d  = (32'(win) == IN_PORTS - 1) ? '0 : win + 1'b1;
                    end else begin
                        lock_d  = 1'b1;
                        owner_d = win;
                    end
                end else if (out_ready[gi]) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ptr_q   <= '0;
                    owner_q <= '0;
                    lock_q  <= 1'b0;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    src_q   <= '0;
                    tail_q  <= 1'b0;
                end else begin
                    ptr_q   <= ptr_d;
                    owner_q <= owner_d;
                    lock_q  <= lock_d;
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    src_q   <= src_d;
                    tail_q  <= tail_d;
                end
            end

            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH]     = data_q;
            assign out_src[gi*IN_PORT_BITS +: IN_PORT_BITS] = src_q;
            assign out_tail[gi]                              = tail_q;
            assign out_valid[gi]                             = valid_q;
        end
    endgenerate

    always_comb begin
        in_ready = bad_port;
        for (int o = 0; o < OUT_PORTS; o++) begin
            for (int i = 0; i < IN_PORTS; i++) begin
                if (grant[o] && (32'(winner[o]) == i)) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= bad_port;
        end
    end

    assign err_port = err_q;

endmodule
